fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of the 4-bit asynchronous FIFO among NREQ requesters in the write clock domain.
- Grants one requester at a time for a burst of up to BURST words, stalls on FIFO full, and drives the FIFO's wr_en/data_in directly.
- Sits between producer blocks and the FIFO write side; the FIFO full flag is the only feedback.

---
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 89 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO write-side bundle for the write-port arbiter
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               full;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_data;
    logic               busy;

    modport master (
        output req, req_data, full,
        input  gnt, ack, fifo_wr_en, fifo_data, busy
    );

    modport slave (
        input  req, req_data, full,
        output gnt, ack, fifo_wr_en, fifo_data, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the async FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 4,
    parameter int BURST = 4
) (
    input  logic               wr_clk,
    input  logic               wr_rst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]      state;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   g_idx;
    logic [PW-1:0]   rr_ptr;
    logic [CW-1:0]   burst_cnt;

    logic [PW-1:0]   pick;
    logic            found;
    int              idx;
    logic            xfer;
    logic            release_g;
    logic [PW-1:0]   next_ptr;

    // Search starts at rr_ptr and wraps, so the requester after the last winner is favoured.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign xfer      = (state == S_GRANT) && bus.req[g_idx] && !bus.full;
    assign release_g = (state == S_GRANT) &&
                       ((xfer && (burst_cnt == CW'(BURST - 1))) || !bus.req[g_idx]);
    assign next_ptr  = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            g_idx     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state     <= S_GRANT;
                        gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        g_idx     <= pick;
                        burst_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (release_g) begin
                        state     <= S_IDLE;
                        gnt       <= '0;
                        burst_cnt <= '0;
                        rr_ptr    <= next_ptr;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt;
    assign bus.ack        = gnt & {NREQ{xfer}};
    assign bus.fifo_wr_en = xfer;
    assign bus.fifo_data  = (state == S_GRANT) ? bus.req_data[int'(g_idx)*DW +: DW] : '0;
    assign bus.busy       = (state == S_GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 4;
    localparam int BURST = 4;

    typedef struct {
        int         idx;
        logic [3:0] data;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic wr_rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_wr  = 0;

    exp_t       exp_q[$];
    logic [DW-1:0] src_q[NREQ][$];
    int         acked[NREQ];

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .wr_clk (clk),
        .wr_rst (wr_rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_src();
        logic [NREQ-1:0]    r;
        logic [NREQ*DW-1:0] d;
        r = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                r[i]          = 1'b1;
                d[i*DW +: DW] = src_q[i][0];
            end
        end
        bus.req      = r;
        bus.req_data = d;
    endtask

    task automatic load(input int i, input logic [3:0] w);
        src_q[i].push_back(w);
    endtask

    task automatic expect_wr(input int i, input logic [3:0] w, input int gap);
        exp_t e;
        e.idx  = i;
        e.data = w;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            acked[i] = 0;
        end
        drive_src();
    endtask

    // One clock: observe acks mid-cycle, then advance each producer just after the edge.
    task automatic cycle();
        logic [NREQ-1:0] a;
        @(negedge clk);
        a = bus.ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (a[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                acked[i]++;
            end
        end
        drive_src();
    endtask

    task automatic do_reset();
        wr_rst   = 1'b0;
        bus.full = 1'b0;
        clear_src();
        repeat (2) @(posedge clk);
        #1;
        wr_rst = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        logic pending;
        k = 0;
        pending = 1'b1;
        while (pending && k < 300) begin
            cycle();
            k++;
            pending = bus.busy;
            for (int i = 0; i < NREQ; i++)
                if (src_q[i].size() > 0) pending = 1'b1;
        end
        chk({name, "_timeout"}, int'(k < 300), 1);
        repeat (2) cycle();
        chk({name, "_sb_drain"}, exp_q.size(), 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.full)
                chk("wr_en_while_full", int'(bus.fifo_wr_en), 0);
            if (bus.fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", int'(bus.fifo_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", int'(bus.fifo_data), int'(e.data));
                    chk("wr_gnt",  int'(bus.gnt), 1 << e.idx);
                    chk("wr_ack",  int'(bus.ack), 1 << e.idx);
                    if (e.gap != 0)
                        chk("wr_gap", cyc - last_wr, e.gap);
                end
                last_wr = cyc;
            end
        end
    endtask

    initial begin
        wr_rst       = 1'b0;
        bus.full     = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        for (int i = 0; i < NREQ; i++) acked[i] = 0;

        fork
            monitor();
        join_none

        // Reset holds everything idle even with all requests up; first grant one edge after release.
        for (int i = 0; i < NREQ; i++) load(i, 4'(i));
        drive_src();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",   int'(bus.gnt), 0);
        chk("rst_ack",   int'(bus.ack), 0);
        chk("rst_wr_en", int'(bus.fifo_wr_en), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_data",  int'(bus.fifo_data), 0);
        @(posedge clk);
        #1;
        wr_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("first_gnt",  int'(bus.gnt), 4'b0001);
        chk("first_busy", int'(bus.busy), 1);

        // Single requester: full burst of four, one idle cycle, then the fifth word.
        do_reset();
        load(2, 4'hA); load(2, 4'hB); load(2, 4'hC); load(2, 4'hD); load(2, 4'hE);
        expect_wr(2, 4'hA, 0); expect_wr(2, 4'hB, 1); expect_wr(2, 4'hC, 1);
        expect_wr(2, 4'hD, 1); expect_wr(2, 4'hE, 2);
        drive_src();
        wait_idle("single");

        // Round-robin over 0,1,3 with continuously held requests.
        do_reset();
        for (int w = 0; w < 8; w++) begin
            load(0, 4'(w));
            load(1, 4'(w + 8));
            load(3, 4'(15 - w));
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) expect_wr(0, 4'(r*4 + k),      (k != 0) ? 1 : (r == 0 ? 0 : 2));
            for (int k = 0; k < 4; k++) expect_wr(1, 4'(r*4 + k + 8),  (k != 0) ? 1 : 2);
            for (int k = 0; k < 4; k++) expect_wr(3, 4'(15 - r*4 - k), (k != 0) ? 1 : 2);
        end
        drive_src();
        wait_idle("rr");

        // Full stall after two words: grant held, no acks, then the last two words.
        do_reset();
        load(0, 4'h1); load(0, 4'h2); load(0, 4'h3); load(0, 4'h4);
        expect_wr(0, 4'h1, 0); expect_wr(0, 4'h2, 1);
        expect_wr(0, 4'h3, 6); expect_wr(0, 4'h4, 1);
        drive_src();
        begin
            int k;
            k = 0;
            while (acked[0] < 2 && k < 20) begin
                cycle();
                k++;
            end
            chk("stall_reach", acked[0], 2);
        end
        bus.full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_ack",   int'(bus.ack), 0);
            chk("stall_wr_en", int'(bus.fifo_wr_en), 0);
            chk("stall_gnt",   int'(bus.gnt), 4'b0001);
            @(posedge clk);
            #1;
        end
        bus.full = 1'b0;
        wait_idle("stall");

        // Early withdrawal by requester 1 hands over to pending requester 2.
        do_reset();
        load(1, 4'h5); load(1, 4'h6);
        load(2, 4'h7); load(2, 4'h8); load(2, 4'h9); load(2, 4'hA); load(2, 4'hB);
        expect_wr(1, 4'h5, 0); expect_wr(1, 4'h6, 1);
        expect_wr(2, 4'h7, 3); expect_wr(2, 4'h8, 1); expect_wr(2, 4'h9, 1);
        expect_wr(2, 4'hA, 1); expect_wr(2, 4'hB, 2);
        drive_src();
        wait_idle("withdraw");

        // Async reset mid-burst on requester 3; arbitration then restarts at index 0.
        do_reset();
        load(1, 4'h1);
        load(3, 4'h6); load(3, 4'h7); load(3, 4'h8); load(3, 4'h9);
        expect_wr(1, 4'h1, 0); expect_wr(3, 4'h6, 3); expect_wr(3, 4'h7, 1);
        drive_src();
        begin
            int k;
            k = 0;
            while (acked[3] < 2 && k < 30) begin
                cycle();
                k++;
            end
            chk("arst_reach", acked[3], 2);
        end
        chk("arst_pre_gnt", int'(bus.gnt), 4'b1000);
        wr_rst = 1'b0;
        #1;
        chk("arst_gnt",   int'(bus.gnt), 0);
        chk("arst_wr_en", int'(bus.fifo_wr_en), 0);
        chk("arst_busy",  int'(bus.busy), 0);
        clear_src();
        load(0, 4'hC);
        load(3, 4'hD);
        expect_wr(0, 4'hC, 0); expect_wr(3, 4'hD, 3);
        drive_src();
        @(posedge clk);
        #1;
        wr_rst = 1'b1;
        wait_idle("arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
